conv_result_packer: RTL and testbench

//  Downstream stage of the convolution accelerator top: consumes the 32-bit result stream
//  (valid/data_out/done) and packs consecutive results into 128-bit words for the 128-bit

---
 rtl/conv_result_packer.sv | 135 +++++++++++++
 tb/tb_conv_result_packer.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_result_packer.sv
// conv_result_packer
// Packs consecutive DW-bit convolution results into LANES-wide words.
// Packed words are queued in a first-word-fall-through FIFO behind a
// valid/ready handshake. A frame end flushes a partial word, or pushes a
// keep=0 marker word when no lanes are pending. Words that arrive while
// the FIFO is full are dropped and raise a sticky overflow flag.
module conv_result_packer #(
    parameter int DW         = 32,
    parameter int LANES      = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    input  logic [DW-1:0]       in_data,
    input  logic                in_done,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [DW*LANES-1:0] out_data,
    output logic [LANES-1:0]    out_keep,
    output logic                out_last,
    output logic                overflow,
    output logic                busy
);
    localparam int WW  = DW * LANES;
    localparam int LCW = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int PW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW  = PW + 1;

    logic [LCW-1:0]   lane_cnt_q, lane_cnt_d;
    logic [DW-1:0]    lane_q [LANES];
    logic [DW-1:0]    lane_d [LANES];
    logic             push;
    logic [WW-1:0]    push_data;
    logic [LANES-1:0] push_keep;
    logic             push_last;
    int               fill;

    logic [WW-1:0]    mem_data [FIFO_DEPTH];
    logic [LANES-1:0] mem_keep [FIFO_DEPTH];
    logic             mem_last [FIFO_DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             overflow_q, overflow_d;
    logic             empty, full, pop, wr_en;

    // Lane packing: place the incoming result and decide whether this cycle closes a word
    always_comb begin
        lane_d     = lane_q;
        fill       = int'(lane_cnt_q);
        push       = 1'b0;
        push_data  = '0;
        push_keep  = '0;
        push_last  = 1'b0;
        if (in_valid) begin
            lane_d[lane_cnt_q] = in_data;
            fill               = fill + 1;
        end
        lane_cnt_d = LCW'(fill);
        if (fill == LANES || in_done) begin
            // Lanes beyond the fill level stay zero; an empty fill yields the marker word.
            push       = 1'b1;
            push_last  = in_done;
            lane_cnt_d = '0;
            for (int k = 0; k < LANES; k++) begin
                if (k < fill) begin
                    push_data[DW*k +: DW] = lane_d[k];
                    push_keep[k]          = 1'b1;
                end
            end
        end
    end

    // Lane registers and lane count
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lane_cnt_q <= '0;
            for (int k = 0; k < LANES; k++) lane_q[k] <= '0;
        end else begin
            lane_cnt_q <= lane_cnt_d;
            for (int k = 0; k < LANES; k++) lane_q[k] <= lane_d[k];
        end
    end

    assign empty = (count_q == '0);
    assign full  = (count_q == CW'(FIFO_DEPTH));
    assign pop   = !empty && out_ready;
    // A pop frees the head slot in the same cycle, so a full FIFO still accepts.
    assign wr_en = push && (!full || pop);

    // FIFO pointer, occupancy and sticky overflow next-state
    always_comb begin
        wr_ptr_d   = wr_en ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d   = pop ? rd_ptr_q + PW'(1) : rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q | (push && full && !pop);
        case ({wr_en, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // FIFO control registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    // FIFO storage; contents are only visible while occupied, so no reset is needed
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_data[wr_ptr_q] <= push_data;
            mem_keep[wr_ptr_q] <= push_keep;
            mem_last[wr_ptr_q] <= push_last;
        end
    end

    assign out_valid = !empty;
    assign out_data  = empty ? '0 : mem_data[rd_ptr_q];
    assign out_keep  = empty ? '0 : mem_keep[rd_ptr_q];
    assign out_last  = empty ? 1'b0 : mem_last[rd_ptr_q];
    assign overflow  = overflow_q;
    assign busy      = (lane_cnt_q != '0) || !empty;

endmodule

// File: tb/tb_conv_result_packer.sv
// Directed testbench for conv_result_packer (DW=32, LANES=4, FIFO_DEPTH=4).
module tb_conv_result_packer;
    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic [31:0]  in_data = '0;
    logic         in_done = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [127:0] out_data;
    logic [3:0]   out_keep;
    logic         out_last;
    logic         overflow;
    logic         busy;

    int checks = 0;
    int failures = 0;

    logic [127:0] cap_data [$];
    logic [3:0]   cap_keep [$];
    logic         cap_last [$];

    conv_result_packer #(.DW(32), .LANES(4), .FIFO_DEPTH(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_done(in_done),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_keep(out_keep), .out_last(out_last), .overflow(overflow), .busy(busy)
    );

    always #5 clk = ~clk;

    // Record every word the downstream side accepts (inputs are stable at this point)
    always @(negedge clk) begin
        #2;
        if (out_valid && out_ready) begin
            cap_data.push_back(out_data);
            cap_keep.push_back(out_keep);
            cap_last.push_back(out_last);
        end
    end

    function automatic logic [127:0] w4(input logic [31:0] l0, input logic [31:0] l1,
                                        input logic [31:0] l2, input logic [31:0] l3);
        return {l3, l2, l1, l0};
    endfunction

    task automatic step(input logic v, input logic [31:0] d, input logic done, input logic rdy);
        @(negedge clk);
        #1;
        in_valid  = v;
        in_data   = d;
        in_done   = done;
        out_ready = rdy;
        @(posedge clk);
        #3;
        in_valid = 1'b0;
        in_done  = 1'b0;
    endtask

    task automatic apply_reset();
        in_valid  = 1'b0;
        in_done   = 1'b0;
        out_ready = 1'b0;
        rst       = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        rst = 1'b1;
    endtask

    task automatic clear_capture();
        cap_data.delete();
        cap_keep.delete();
        cap_last.delete();
    endtask

    task automatic test_reset();
        #1;
        rst = 1'b0;
        #2;
        checks++;
        if ({out_valid, out_keep, out_last, overflow, busy} !== 8'b0 || out_data !== '0) begin
            failures++;
            $display("FAIL reset_outputs: got valid=%b keep=%h last=%b ovf=%b busy=%b data=%h, want all 0",
                     out_valid, out_keep, out_last, overflow, busy, out_data);
        end
        repeat (2) @(negedge clk);
        #1;
        rst = 1'b1;
    endtask

    task automatic test_nine_results();
        clear_capture();
        for (int i = 1; i <= 9; i++) step(1'b1, 32'(i), (i == 9), 1'b1);
        step(1'b0, 32'd0, 1'b0, 1'b1);
        step(1'b0, 32'd0, 1'b0, 1'b1);
        checks++;
        if (cap_data.size() != 3) begin
            failures++;
            $display("FAIL nine_count: got %0d words, want 3", cap_data.size());
        end else begin
            checks++;
            if (cap_data[0] !== w4(1, 2, 3, 4) || cap_keep[0] !== 4'hF || cap_last[0] !== 1'b0) begin
                failures++;
                $display("FAIL nine_w0: got %h k=%h l=%b, want %h k=f l=0", cap_data[0], cap_keep[0], cap_last[0], w4(1, 2, 3, 4));
            end
            checks++;
            if (cap_data[1] !== w4(5, 6, 7, 8) || cap_keep[1] !== 4'hF || cap_last[1] !== 1'b0) begin
                failures++;
                $display("FAIL nine_w1: got %h k=%h l=%b, want %h k=f l=0", cap_data[1], cap_keep[1], cap_last[1], w4(5, 6, 7, 8));
            end
            checks++;
            if (cap_data[2] !== w4(9, 0, 0, 0) || cap_keep[2] !== 4'h1 || cap_last[2] !== 1'b1) begin
                failures++;
                $display("FAIL nine_w2: got %h k=%h l=%b, want %h k=1 l=1", cap_data[2], cap_keep[2], cap_last[2], w4(9, 0, 0, 0));
            end
        end
        checks++;
        if (overflow !== 1'b0 || busy !== 1'b0 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL nine_idle: got ovf=%b busy=%b valid=%b, want 0 0 0", overflow, busy, out_valid);
        end
    endtask

    task automatic test_late_done();
        clear_capture();
        step(1'b1, 32'hA, 1'b0, 1'b1);
        step(1'b1, 32'hB, 1'b0, 1'b1);
        step(1'b1, 32'hC, 1'b0, 1'b1);
        step(1'b1, 32'hD, 1'b0, 1'b1);
        step(1'b0, 32'h0, 1'b0, 1'b1);
        step(1'b0, 32'h0, 1'b1, 1'b1);
        step(1'b0, 32'h0, 1'b0, 1'b1);
        step(1'b0, 32'h0, 1'b0, 1'b1);
        checks++;
        if (cap_data.size() != 2) begin
            failures++;
            $display("FAIL late_count: got %0d words, want 2", cap_data.size());
        end else begin
            checks++;
            if (cap_data[0] !== w4(32'hA, 32'hB, 32'hC, 32'hD) || cap_keep[0] !== 4'hF || cap_last[0] !== 1'b0) begin
                failures++;
                $display("FAIL late_word: got %h k=%h l=%b, want %h k=f l=0", cap_data[0], cap_keep[0], cap_last[0],
                         w4(32'hA, 32'hB, 32'hC, 32'hD));
            end
            checks++;
            if (cap_data[1] !== '0 || cap_keep[1] !== 4'h0 || cap_last[1] !== 1'b1) begin
                failures++;
                $display("FAIL late_marker: got %h k=%h l=%b, want 0 k=0 l=1", cap_data[1], cap_keep[1], cap_last[1]);
            end
        end
    endtask

    task automatic test_done_with_fourth();
        clear_capture();
        for (int i = 0; i < 4; i++) step(1'b1, 32'h20 + 32'(i), (i == 3), 1'b1);
        step(1'b0, 32'h0, 1'b0, 1'b1);
        step(1'b0, 32'h0, 1'b0, 1'b1);
        checks++;
        if (cap_data.size() != 1) begin
            failures++;
            $display("FAIL done4_count: got %0d words, want 1", cap_data.size());
        end else begin
            checks++;
            if (cap_data[0] !== w4(32'h20, 32'h21, 32'h22, 32'h23) || cap_keep[0] !== 4'hF || cap_last[0] !== 1'b1) begin
                failures++;
                $display("FAIL done4_word: got %h k=%h l=%b, want %h k=f l=1", cap_data[0], cap_keep[0], cap_last[0],
                         w4(32'h20, 32'h21, 32'h22, 32'h23));
            end
        end
    endtask

    task automatic test_overflow();
        apply_reset();
        clear_capture();
        for (int i = 1; i <= 16; i++) step(1'b1, 32'(i), 1'b0, 1'b0);
        checks++;
        if (out_valid !== 1'b1 || out_data !== w4(1, 2, 3, 4) || overflow !== 1'b0) begin
            failures++;
            $display("FAIL ovf_full: got valid=%b data=%h ovf=%b, want 1 %h 0", out_valid, out_data, overflow, w4(1, 2, 3, 4));
        end
        for (int i = 17; i <= 20; i++) step(1'b1, 32'(i), 1'b0, 1'b0);
        checks++;
        if (overflow !== 1'b1 || out_data !== w4(1, 2, 3, 4) || out_keep !== 4'hF) begin
            failures++;
            $display("FAIL ovf_set: got ovf=%b data=%h keep=%h, want 1 %h f", overflow, out_data, out_keep, w4(1, 2, 3, 4));
        end
        for (int i = 0; i < 5; i++) step(1'b0, 32'h0, 1'b0, 1'b1);
        checks++;
        if (cap_data.size() != 4) begin
            failures++;
            $display("FAIL ovf_count: got %0d words, want 4", cap_data.size());
        end else begin
            for (int w = 0; w < 4; w++) begin
                checks++;
                if (cap_data[w] !== w4(32'(4*w+1), 32'(4*w+2), 32'(4*w+3), 32'(4*w+4))) begin
                    failures++;
                    $display("FAIL ovf_word%0d: got %h, want %h", w, cap_data[w],
                             w4(32'(4*w+1), 32'(4*w+2), 32'(4*w+3), 32'(4*w+4)));
                end
            end
        end
        checks++;
        if (overflow !== 1'b1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL ovf_sticky: got ovf=%b busy=%b, want 1 0", overflow, busy);
        end
    endtask

    task automatic test_back_to_back();
        apply_reset();
        clear_capture();
        checks++;
        if (overflow !== 1'b0) begin
            failures++;
            $display("FAIL b2b_ovf_cleared: got %b, want 0", overflow);
        end
        for (int i = 1; i <= 19; i++) step(1'b1, 32'(i), 1'b0, 1'b0);
        step(1'b1, 32'd20, 1'b0, 1'b1);
        checks++;
        if (overflow !== 1'b0 || out_valid !== 1'b1 || out_data !== w4(5, 6, 7, 8) || cap_data.size() != 1) begin
            failures++;
            $display("FAIL b2b_full_pushpop: got ovf=%b valid=%b data=%h popped=%0d, want 0 1 %h 1",
                     overflow, out_valid, out_data, cap_data.size(), w4(5, 6, 7, 8));
        end
        for (int i = 0; i < 5; i++) step(1'b0, 32'h0, 1'b0, 1'b1);
        checks++;
        if (cap_data.size() != 5) begin
            failures++;
            $display("FAIL b2b_count: got %0d words, want 5", cap_data.size());
        end else begin
            for (int w = 0; w < 5; w++) begin
                checks++;
                if (cap_data[w] !== w4(32'(4*w+1), 32'(4*w+2), 32'(4*w+3), 32'(4*w+4)) || cap_keep[w] !== 4'hF) begin
                    failures++;
                    $display("FAIL b2b_word%0d: got %h k=%h, want %h k=f", w, cap_data[w], cap_keep[w],
                             w4(32'(4*w+1), 32'(4*w+2), 32'(4*w+3), 32'(4*w+4)));
                end
            end
        end
    endtask

    task automatic test_mid_frame_reset();
        clear_capture();
        for (int i = 1; i <= 6; i++) step(1'b1, 32'(i), 1'b0, 1'b0);
        checks++;
        if (out_valid !== 1'b1 || busy !== 1'b1) begin
            failures++;
            $display("FAIL mid_pre: got valid=%b busy=%b, want 1 1", out_valid, busy);
        end
        #1;
        rst = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || out_data !== '0) begin
            failures++;
            $display("FAIL mid_reset: got valid=%b busy=%b data=%h, want 0 0 0", out_valid, busy, out_data);
        end
        repeat (2) @(negedge clk);
        #1;
        rst = 1'b1;
        for (int i = 0; i < 4; i++) step(1'b1, 32'h61 + 32'(i), (i == 3), 1'b1);
        step(1'b0, 32'h0, 1'b0, 1'b1);
        step(1'b0, 32'h0, 1'b0, 1'b1);
        checks++;
        if (cap_data.size() != 1) begin
            failures++;
            $display("FAIL mid_count: got %0d words, want 1", cap_data.size());
        end else begin
            checks++;
            if (cap_data[0] !== w4(32'h61, 32'h62, 32'h63, 32'h64) || cap_keep[0] !== 4'hF || cap_last[0] !== 1'b1) begin
                failures++;
                $display("FAIL mid_word: got %h k=%h l=%b, want %h k=f l=1", cap_data[0], cap_keep[0], cap_last[0],
                         w4(32'h61, 32'h62, 32'h63, 32'h64));
            end
        end
    endtask

    initial begin
        test_reset();
        test_nine_results();
        test_late_done();
        test_done_with_fourth();
        test_overflow();
        test_back_to_back();
        test_mid_frame_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
